barrel_shifter_rr_scheduler: RTL and testbench

- Shares one 8-bit rotate-left/right datapath between two requesters.
- Round-robin arbitration and per-request valid/ready handshakes.
- Three-state FSM sequences each operation: accept, compute, respond.
- Registered response port, busy flag and a completed-operation counter for status/debug.

---
 rtl/barrel_shifter_rr_scheduler.sv | 138 +++++++++++++
 tb/tb_barrel_shifter_rr_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_rr_scheduler.sv
// Two-requester round-robin scheduler in front of one shared 8-bit rotator.
// Each operation walks IDLE -> EXEC -> RESP. The response port is fully
// registered, so no input reaches rsp_* combinationally.
module barrel_shifter_rr_scheduler #(
  parameter int FIRST_PRIO = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_data,
  input  logic [2:0]       req0_amt,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_data,
  input  logic [2:0]       req1_amt,
  input  logic             req1_dir,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  // last_grant starts as the non-priority side so FIRST_PRIO wins the first tie
  localparam logic LAST_GRANT_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_last_grant;
  logic [7:0]       r_data;
  logic [2:0]       r_amt;
  logic             r_dir;
  logic             r_id;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_data;
  logic             r_rsp_id;
  logic [CNT_W-1:0] r_op_count;

  logic             w_any_valid;
  logic             w_winner;
  logic             w_idle;
  logic             w_accept;
  logic [15:0]      w_dbl;
  logic [15:0]      w_shr;
  logic [15:0]      w_shl;
  logic [7:0]       w_rot;

  assign w_idle      = (r_state == S_IDLE);
  assign w_any_valid = req0_valid | req1_valid;
  assign w_accept    = w_idle & w_any_valid;

  // Arbitration: a lone requester wins; on a tie the side not granted last wins
  always_comb begin
    w_winner = 1'b0;
    if (req0_valid && req1_valid) begin
      w_winner = ~r_last_grant;
    end else if (req1_valid) begin
      w_winner = 1'b1;
    end
  end

  assign req0_ready = w_idle & ~w_winner & req0_valid;
  assign req1_ready = w_idle &  w_winner & req1_valid;

  // Rotation on a doubled word: right uses the low byte of a right shift,
  // left uses the high byte of a left shift
  assign w_dbl = {r_data, r_data};
  assign w_shr = w_dbl >> r_amt;
  assign w_shl = w_dbl << r_amt;
  assign w_rot = r_dir ? w_shr[7:0] : w_shl[15:8];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_any_valid) w_state_next = S_EXEC;
      S_EXEC: w_state_next = S_RESP;
      S_RESP: if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture the winning operand set and remember who was granted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data       <= 8'd0;
      r_amt        <= 3'd0;
      r_dir        <= 1'b0;
      r_id         <= 1'b0;
      r_last_grant <= LAST_GRANT_RST;
    end else if (w_accept) begin
      r_data       <= w_winner ? req1_data : req0_data;
      r_amt        <= w_winner ? req1_amt  : req0_amt;
      r_dir        <= w_winner ? req1_dir  : req0_dir;
      r_id         <= w_winner;
      r_last_grant <= w_winner;
    end
  end

  // Response register and completed-operation counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'd0;
      r_rsp_id    <= 1'b0;
      r_op_count  <= '0;
    end else if (r_state == S_EXEC) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_rot;
      r_rsp_id    <= r_id;
    end else if (r_state == S_RESP && rsp_ready) begin
      r_rsp_valid <= 1'b0;
      r_op_count  <= r_op_count + 1'b1;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = ~w_idle;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_barrel_shifter_rr_scheduler.sv
// Bench for barrel_shifter_rr_scheduler: directed scenarios followed by
// random traffic, with a reference model and a response scoreboard.
module tb_barrel_shifter_rr_scheduler;

  localparam int FIRST_PRIO = 0;
  localparam int CNT_W      = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req0_valid = 1'b0;
  logic             req0_ready;
  logic [7:0]       req0_data = 8'd0;
  logic [2:0]       req0_amt = 3'd0;
  logic             req0_dir = 1'b0;
  logic             req1_valid = 1'b0;
  logic             req1_ready;
  logic [7:0]       req1_data = 8'd0;
  logic [2:0]       req1_amt = 3'd0;
  logic             req1_dir = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_data;
  logic             rsp_id;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  barrel_shifter_rr_scheduler #(.FIRST_PRIO(FIRST_PRIO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: rotate bit by bit from the index rule
  function automatic logic [7:0] ref_rot(input logic [7:0] d, input logic [2:0] amt, input logic dir);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) begin
      if (dir) o[i] = d[(i + int'(amt)) % 8];
      else     o[i] = d[(i + 8 - int'(amt)) % 8];
    end
    return o;
  endfunction

  function automatic logic ref_winner(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  // Model: one operation in flight at a time; result shows two cycles after accept
  logic        m_pending = 1'b0;
  int          m_acc     = 0;
  int          cyc       = 0;
  logic        m_last    = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;
  int          m_count   = 0;
  logic [8:0]  exp_q[$];

  // Model update at each active edge from the inputs sampled there
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pending = 1'b0;
      m_last    = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;
      m_count   = 0;
    end else begin
      if (!m_pending && (req0_valid || req1_valid)) begin
        logic w;
        w = ref_winner(req0_valid, req1_valid, m_last);
        m_last    = w;
        m_pending = 1'b1;
        m_acc     = cyc;
        if (w) exp_q.push_back({1'b1, ref_rot(req1_data, req1_amt, req1_dir)});
        else   exp_q.push_back({1'b0, ref_rot(req0_data, req0_amt, req0_dir)});
        $display("accept req%0d at cycle %0d", w, cyc);
      end else if (m_pending && cyc >= m_acc + 2 && rsp_ready) begin
        m_pending = 1'b0;
        m_count   = (m_count + 1) % (1 << CNT_W);
      end
      cyc++;
    end
  end

  // Control/status checker on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_op_count", 32'(op_count), 32'd0);
      check("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
      check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
    end else begin
      logic e0, e1, w;
      w  = ref_winner(req0_valid, req1_valid, m_last);
      e0 = !m_pending && !w && req0_valid;
      e1 = !m_pending &&  w && req1_valid;
      check("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
      check("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
      check("busy", {31'd0, busy}, {31'd0, m_pending});
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, (m_pending && cyc >= m_acc + 2)});
      check("op_count", 32'(op_count), 32'(m_count));
    end
  end

  // Scoreboard monitor: compare every presented response, pop on handshake
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d data=%02h expected no response", rsp_id, rsp_data);
      end else begin
        check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q[0][7:0]});
        check("rsp_id", {31'd0, rsp_id}, {31'd0, exp_q[0][8]});
        if (rsp_ready) begin
          $display("response id=%0d data=%02h op_count=%0d", rsp_id, rsp_data, op_count);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input bit n, input bit v, input logic [7:0] d, input logic [2:0] a, input logic dir);
    if (n) begin
      req1_valid = v; req1_data = d; req1_amt = a; req1_dir = dir;
    end else begin
      req0_valid = v; req0_data = d; req0_amt = a; req0_dir = dir;
    end
  endtask

  // Present a request until it is accepted, then withdraw it
  task automatic send(input bit n, input logic [7:0] d, input logic [2:0] a, input logic dir);
    bit got;
    got = 1'b0;
    set_req(n, 1'b1, d, a, dir);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (n ? req1_ready : req0_ready) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout: req%0d got no ready expected ready within 40 cycles", n);
    end
    @(posedge clk);
    #1;
    set_req(n, 1'b0, 8'd0, 3'd0, 1'b0);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0d expected 0 within 40 cycles", busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Single right rotate, then left rotate, then pass-through
    rsp_ready = 1'b1;
    send(1'b0, 8'b1000_0001, 3'd1, 1'b1);
    wait_idle();
    send(1'b1, 8'hA5, 3'd3, 1'b0);
    wait_idle();
    send(1'b1, 8'hA5, 3'd0, 1'b1);
    wait_idle();

    // Backpressure: response held for a dozen cycles
    rsp_ready = 1'b0;
    send(1'b1, 8'h3C, 3'd5, 1'b1);
    set_req(1'b0, 1'b1, 8'h11, 3'd2, 1'b0);
    tick(12);
    rsp_ready = 1'b1;
    tick(1);
    set_req(1'b0, 1'b0, 8'd0, 3'd0, 1'b0);
    wait_idle();

    // Contention from reset, then reset during EXEC and contention again
    set_req(1'b0, 1'b1, 8'h81, 3'd1, 1'b1);
    set_req(1'b1, 1'b1, 8'hA5, 3'd3, 1'b0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(13);
    begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) got = 1'b1;
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
    end
    tick(13);
    set_req(1'b0, 1'b0, 8'd0, 3'd0, 1'b0);
    set_req(1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
    wait_idle();

    // Random traffic: fields may change or drop at any time before acceptance
    for (int k = 0; k < 400; k++) begin
      set_req(1'b0, ($urandom_range(0, 99) < 50), 8'($urandom), 3'($urandom), 1'($urandom));
      set_req(1'b1, ($urandom_range(0, 99) < 50), 8'($urandom), 3'($urandom), 1'($urandom));
      rsp_ready = ($urandom_range(0, 99) < 70);
      tick(1);
    end

    set_req(1'b0, 1'b0, 8'd0, 3'd0, 1'b0);
    set_req(1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
    rsp_ready = 1'b1;
    wait_idle();
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
